// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl
//   E-stage multiply/divide sequencer and owner of the architectural HI/LO
//   registers. A MULT/MULTU/DIV/DIVU start latches its operands and loads a
//   latency countdown. HI/LO commit on the edge where the count reaches one.
//   MTHI/MTLO write HI/LO directly from IDLE. E_Busy and MD_Stall feed the
//   hazard unit so that MD-class instructions in D wait for the unit.
//
//   Build option: define MDU_ABORT_EN to add E_Abort. E_Abort flushes an
//   in-flight operation, or suppresses a start in the same cycle.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous active-low clear
//   E_Start   in   1   E-stage MD instruction valid
//   E_MDOp    in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   E_A       in   32  rs operand
//   E_B       in   32  rt operand
//   D_IsMD    in   1   D-stage instruction is MD-class (incl. MFHI/MFLO)
//   E_Busy    out  1   unit occupied (mult/div start this cycle, or counting)
//   MD_Stall  out  1   D_IsMD & E_Busy
//   HI        out  32  architectural HI
//   LO        out  32  architectural LO
//   E_Abort   in   1   flush (only with MDU_ABORT_EN)
//
// state | meaning
// IDLE  | no operation in flight; MTHI/MTLO and new starts accepted
// BUSY  | mult/div counting down; commits HI/LO when cnt==1

module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [2:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_IsMD,
`ifdef MDU_ABORT_EN
  input  logic        E_Abort,
`endif
  output logic        E_Busy,
  output logic        MD_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    op_q, op_nxt;
  logic [31:0]   a_q, a_nxt;
  logic [31:0]   b_q, b_nxt;
  logic [31:0]   hi_q, hi_nxt;
  logic [31:0]   lo_q, lo_nxt;
  logic          busy_int;
  logic          abort;

`ifdef MDU_ABORT_EN
  assign abort = E_Abort;
`else
  assign abort = 1'b0;
`endif

  // Result datapath on the latched operands. Signed multiply uses
  // sign-extended 64-bit operands; the low 64 bits of the unsigned product
  // equal the two's-complement signed product.
  logic [63:0] mul_a, mul_b, prod;
  logic        op_signed;
  logic [31:0] abs_a, abs_b, div_b, uq, ur, quo, rem;
  logic        div_by_zero;

  assign op_signed   = ~op_q[0];
  assign mul_a       = {(op_signed ? {32{a_q[31]}} : 32'h0), a_q};
  assign mul_b       = {(op_signed ? {32{b_q[31]}} : 32'h0), b_q};
  assign prod        = mul_a * mul_b;

  // Signed divide via magnitudes: quotient negated when signs differ,
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign abs_a       = (op_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign abs_b       = (op_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign div_by_zero = (b_q == 32'h0);
  assign div_b       = div_by_zero ? 32'd1 : abs_b;
  assign uq          = abs_a / div_b;
  assign ur          = abs_a % div_b;
  assign quo         = (op_signed && (a_q[31] ^ b_q[31])) ? (~uq + 32'd1) : uq;
  assign rem         = (op_signed && a_q[31]) ? (~ur + 32'd1) : ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 2'd0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    busy_int  = 1'b0;
    case (state)
      IDLE: begin
        if (E_Start && !abort) begin
          if (E_MDOp[2] == 1'b0) begin
            op_nxt    = E_MDOp[1:0];
            a_nxt     = E_A;
            b_nxt     = E_B;
            cnt_nxt   = E_MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_nxt = BUSY;
            busy_int  = 1'b1;
          end else if (E_MDOp == 3'd4) begin
            hi_nxt = E_A;
          end else if (E_MDOp == 3'd5) begin
            lo_nxt = E_A;
          end
        end
      end
      BUSY: begin
        busy_int = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (!op_q[1]) begin
            hi_nxt = prod[63:32];
            lo_nxt = prod[31:0];
          end else if (!div_by_zero) begin
            hi_nxt = rem;
            lo_nxt = quo;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Gated by reset so the start-cycle busy cannot leak out while held in reset.
  assign E_Busy   = busy_int & reset;
  assign MD_Stall = D_IsMD & E_Busy;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
